phy_tx_par: RTL and testbench

Parametrised PHY transmit serializer: the next generation of the two-lane, 8-bit `phy_tx` block. It runs on a single bit-rate clock and serializes `NUM_LANES` independent `WIDTH`-bit lanes, MSB- or LSB-first. A post-reset link-training phase sends `SYNC_WORDS` `IDLE` symbols on every lane before raising `link_up`. After that, a word-rate `in_ready` strobe accepts data, and any lane with `valid_in` low carries `IDLE`.

---
 rtl/phy_tx_par.sv | 57 +++++
 tb/tb_phy_tx_par.sv | 109 ++++++++++
 2 files changed

// File: rtl/phy_tx_par.sv
// phy_tx_par: multi-lane word serializer with post-reset IDLE link training
module phy_tx_par #(
   parameter int NUM_LANES = 2,
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] IDLE = WIDTH'(8'hBC),
   parameter int SYNC_WORDS = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                         clk_8f,
   input  logic                         reset,
   input  logic [NUM_LANES*WIDTH-1:0]   data_in,
   input  logic [NUM_LANES-1:0]         valid_in,
   output logic                         in_ready,
   output logic [NUM_LANES-1:0]         serial_out,
   output logic                         word_start,
   output logic                         link_up
);
   localparam int CW = $clog2(WIDTH);
   localparam int SW = $clog2(SYNC_WORDS + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_WORDS - 1);
   typedef enum logic {SYNC, ACTIVE} state_t;
   state_t r_state;
   logic [CW-1:0] r_cnt;
   logic [SW-1:0] r_sync_cnt;
   logic [NUM_LANES-1:0][WIDTH-1:0] r_shreg, w_next;
   logic w_load;
   assign w_load = r_cnt == LAST;
   // lanes without valid data, and every lane during training, carry IDLE
   always_comb begin
      w_next = '0;
      for (int l = 0; l < NUM_LANES; l++)
         w_next[l] = !w_load ? (MSB_FIRST ? r_shreg[l] << 1 : r_shreg[l] >> 1) :
                     (r_state == ACTIVE && valid_in[l]) ? data_in[l*WIDTH +: WIDTH] : IDLE;
   end
   always_ff @(posedge clk_8f) begin
      if (reset) begin
         r_state    <= SYNC;
         r_cnt      <= LAST;
         r_sync_cnt <= '0;
         r_shreg    <= '0;
      end else begin
         r_cnt   <= w_load ? '0 : r_cnt + 1'b1;
         r_shreg <= w_next;
         if (w_load && r_state == SYNC) begin
            r_sync_cnt <= r_sync_cnt + 1'b1;
            if (r_sync_cnt == SYNC_LAST) r_state <= ACTIVE;
         end
      end
   end
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign serial_out[g] = MSB_FIRST ? r_shreg[g][WIDTH-1] : r_shreg[g][0];
   end
   assign in_ready   = r_state == ACTIVE && w_load;
   assign word_start = r_cnt == '0;
   assign link_up    = r_state == ACTIVE;
endmodule

// File: tb/tb_phy_tx_par.sv
// tb_phy_tx_par: randomized and directed checks of three phy_tx_par configurations against a bit-stream model
module tb_phy_tx_par;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic [2:0] rst = '1;
   logic [39:0] din = '0;
   logic [3:0] vin = '0;
   logic [1:0] ser0, ser1;
   logic [3:0] ser2;
   logic [2:0] ir, ws, lu;
   int sel = 0;
   int errs = 0;
   int checks = 0;
   logic [9:0] wd [4][32];
   logic vd [4][32];
   logic [3:0] o_ser;
   always_comb o_ser = sel == 0 ? {2'b0, ser0} : sel == 1 ? {2'b0, ser1} : ser2;

   phy_tx_par u0 (.clk_8f(clk), .reset(rst[0]), .data_in(din[15:0]), .valid_in(vin[1:0]),
      .in_ready(ir[0]), .serial_out(ser0), .word_start(ws[0]), .link_up(lu[0]));
   phy_tx_par #(.WIDTH(10), .IDLE(10'h17C), .MSB_FIRST(1'b0)) u1 (.clk_8f(clk), .reset(rst[1]),
      .data_in(din[19:0]), .valid_in(vin[1:0]), .in_ready(ir[1]), .serial_out(ser1),
      .word_start(ws[1]), .link_up(lu[1]));
   phy_tx_par #(.NUM_LANES(4)) u2 (.clk_8f(clk), .reset(rst[2]), .data_in(din[31:0]),
      .valid_in(vin[3:0]), .in_ready(ir[2]), .serial_out(ser2), .word_start(ws[2]), .link_up(lu[2]));

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic fill(input int w);
      for (int l = 0; l < 4; l++)
         for (int k = 0; k < 32; k++) begin
            wd[l][k] = 10'($urandom) & ((10'd1 << w) - 10'd1);
            vd[l][k] = 1'($urandom_range(0, 1));
         end
   endtask

   // word k of the line: IDLE for the four training words, then whatever was offered in cycle k*w
   task automatic run(input int s, input int nl, input int w, input bit msb, input logic [9:0] idle,
                      input int nwords, input int abort_k);
      int last, k, b, kd;
      logic [3:0] es;
      logic [9:0] word;
      last = (4 + nwords) * w;
      sel = s;
      rst[s] = 1'b0;
      for (int n = 0; n <= last; n++) begin
         es = '0;
         k = n > 0 ? (n - 1) / w : 0;
         b = n > 0 ? (n - 1) % w : 0;
         if (n > 0)
            for (int l = 0; l < nl; l++) begin
               word = (k < 4 || !vd[l][k]) ? idle : wd[l][k];
               es[l] = msb ? word[w-1-b] : word[b];
            end
         chk("serial_out", o_ser, es);
         chk("word_start", 4'(ws[s]), 4'(n > 0 && b == 0));
         chk("in_ready", 4'(ir[s]), 4'(n >= 4 * w && n % w == 0));
         chk("link_up", 4'(lu[s]), 4'(n >= 3 * w + 1));
         if (abort_k >= 0 && n > 0 && k == abort_k && b == 3) begin
            rst[s] = 1'b1;
            @(posedge clk); #1;
            return;
         end
         din = {8'($urandom), $urandom};
         vin = 4'($urandom);
         if (n >= 4 * w && n % w == 0) begin
            kd = n / w;
            for (int l = 0; l < nl; l++) begin
               vin[l] = kd < 32 ? vd[l][kd] : 1'b0;
               for (int i = 0; i < w; i++) din[l*w+i] = kd < 32 ? wd[l][kd][i] : 1'b0;
            end
         end
         @(posedge clk); #1;
      end
      rst[s] = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      fill(8);
      wd[0][4] = 10'hA5; vd[0][4] = 1'b1; vd[1][4] = 1'b0;
      wd[0][5] = 10'h01; vd[0][5] = 1'b1;
      wd[0][6] = 10'hFF; vd[0][6] = 1'b1;
      run(0, 2, 8, 1'b1, 10'hBC, 8, -1);
      fill(8);
      run(0, 2, 8, 1'b1, 10'hBC, 8, 5);
      fill(8);
      run(0, 2, 8, 1'b1, 10'hBC, 4, -1);
      fill(10);
      wd[0][4] = 10'h001; vd[0][4] = 1'b1;
      run(1, 2, 10, 1'b0, 10'h17C, 6, -1);
      fill(8);
      for (int l = 0; l < 4; l++) begin
         wd[l][4] = 10'h10 + 10'(l);
         vd[l][4] = 1'b1;
      end
      run(2, 4, 8, 1'b1, 10'hBC, 6, -1);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
